// File: rtl/lsu_bus_bridge_pkg.sv
// Shared definitions for the load/store bus bridge: width codes, fault causes,
// FSM states and the byte-lane helpers used when a MEM-stage access is launched.
package lsu_bus_bridge_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS_ERR = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic access_illegal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic bad;
    case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = a[0];
      F3_LW:         bad = (a != 2'b00);
      default:       bad = 1'b1;
    endcase
    // Stores only exist as SB/SH/SW.
    if (we && (f3 > F3_LW)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_bridge_load_align.sv
// Picks the addressed byte/half lane out of a bus word and sign- or zero-extends it.
module lsu_load_align
  import lsu_bus_bridge_pkg::*;
(
  input  logic [1:0]  a_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    shifted = word_i >> {a_i, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = a_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  data_o = {24'd0, lane_b};
      F3_LH:   data_o = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  data_o = {16'd0, lane_h};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// MEM-stage load/store bridge: one access becomes one word-aligned bus beat,
// the pipeline stalls until it resolves, then a single DONE cycle reports the result.
module lsu_bus_bridge
  import lsu_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rsp_valid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  localparam int CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(TMO_LAST);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic              load_valid_q, load_valid_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       rdata_aligned;
  logic              timeout_hit;

  lsu_load_align u_align (
    .a_i      (addr_lo_q),
    .funct3_i (funct3_q),
    .word_i   (bus_rdata_i),
    .data_o   (rdata_aligned)
  );

  // ">=" rather than "==" so a grant on the last allowed cycle still bounds the RSP wait.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q >= TMO_LAST_C);

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    load_valid_d = 1'b0;
    load_data_d  = 32'd0;
    fault_d      = 1'b0;
    cause_d      = CAUSE_NONE;
    stall_o      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          stall_o   = 1'b1;
          we_d      = req_we_i;
          addr_lo_d = req_addr_i[1:0];
          funct3_d  = req_funct3_i;
          cnt_d     = '0;
          if (access_illegal(req_we_i, req_funct3_i, req_addr_i[1:0])) begin
            state_d = ST_DONE;
            fault_d = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            state_d     = ST_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we_i;
            bus_addr_d  = {req_addr_i[31:2], 2'b00};
            bus_be_d    = byte_enables(req_funct3_i, req_addr_i[1:0]);
            bus_wdata_d = req_we_i ? replicate_wdata(req_funct3_i, req_wdata_i) : 32'd0;
          end
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        if (bus_gnt_i || timeout_hit) begin
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = 32'd0;
          bus_wdata_d = 32'd0;
          bus_be_d    = 4'd0;
        end
        if (bus_gnt_i) begin
          state_d = ST_RSP;
          cnt_d   = cnt_q + 1'b1;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RSP: begin
        stall_o = 1'b1;
        if (bus_rsp_valid_i) begin
          state_d = ST_DONE;
          if (bus_err_i) begin
            fault_d = 1'b1;
            cause_d = CAUSE_BUS_ERR;
          end else if (!we_q) begin
            load_valid_d = 1'b1;
            load_data_d  = rdata_aligned;
          end
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      addr_lo_q    <= 2'd0;
      funct3_q     <= 3'd0;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_wdata_q  <= 32'd0;
      bus_be_q     <= 4'd0;
      load_valid_q <= 1'b0;
      load_data_q  <= 32'd0;
      fault_q      <= 1'b0;
      cause_q      <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
    end
  end

  assign load_data_o   = load_data_q;
  assign load_valid_o  = load_valid_q;
  assign fault_o       = fault_q;
  assign fault_cause_o = cause_q;
  assign bus_req_o     = bus_req_q;
  assign bus_we_o      = bus_we_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign bus_be_o      = bus_be_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Bench for lsu_bus_bridge: directed vector table, randomized accesses against a
// behavioural model, plus reset-mid-access and late-response sequences.
module tb_lsu_bus_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [2:0]  req_funct3_i;
  logic        stall_o, load_valid_o, fault_o;
  logic [31:0] load_data_o;
  logic [1:0]  fault_cause_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rsp_valid_i, bus_err_i;
  logic [31:0] bus_rdata_i;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  lsu_bus_bridge #(.TIMEOUT_CYC(255)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_funct3_i(req_funct3_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
    .fault_o(fault_o), .fault_cause_o(fault_cause_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_gnt_i(bus_gnt_i), .bus_rsp_valid_i(bus_rsp_valid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          gnt_dly;
    int          rsp_dly;
    logic        err;
    logic        no_rsp;
    logic        noise;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic        lv;
    logic        flt;
    logic [1:0]  cause;
    logic [31:0] ldata;
    int          stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, input int gnt, input int rsp, input logic err,
                              input logic no_rsp, input logic [31:0] rdata, input logic [3:0] be,
                              input logic [31:0] bwdata, input logic lv, input logic flt,
                              input logic [1:0] cause, input logic [31:0] ldata, input int stall);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3; v.gnt_dly = gnt; v.rsp_dly = rsp;
    v.err = err; v.no_rsp = no_rsp; v.noise = 1'b0; v.rdata = rdata; v.be = be;
    v.bwdata = bwdata; v.lv = lv; v.flt = flt; v.cause = cause; v.ldata = ldata; v.stall = stall;
    return v;
  endfunction

  // Reference: size in bytes, alignment by modulo, extension by masking.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int size, a;
    logic illegal, tmo;
    logic [31:0] sh, mask;
    r = v;
    size = 1 << v.f3[1:0];
    a = int'(v.addr[1:0]);
    illegal = (v.f3[1:0] == 2'b11) || (v.f3 == 3'b110) || (v.we && v.f3 > 3'd2) || ((a % size) != 0);
    if (size > 4) size = 4;
    tmo = !illegal && (v.no_rsp || v.gnt_dly >= 255 || (v.gnt_dly + v.rsp_dly + 2) > 255);
    r.be = illegal ? 4'd0 : 4'(((1 << size) - 1) << a);
    r.bwdata = 32'd0;
    if (!illegal && v.we)
      for (int i = 0; i < 4; i++) r.bwdata[8*i +: 8] = v.wdata[8*(i % size) +: 8];
    sh = v.rdata >> (8 * a);
    if (size == 4) r.ldata = sh;
    else begin
      mask = (32'd1 << (8 * size)) - 32'd1;
      r.ldata = sh & mask;
      if (!v.f3[2] && sh[8*size-1]) r.ldata = r.ldata | ~mask;
    end
    r.flt = illegal || tmo || v.err;
    r.lv = !r.flt && !v.we;
    if (!r.lv) r.ldata = 32'd0;
    r.cause = illegal ? 2'd1 : tmo ? 2'd3 : v.err ? 2'd2 : 2'd0;
    r.stall = illegal ? 1 : tmo ? 256 : v.gnt_dly + v.rsp_dly + 3;
    return r;
  endfunction

  // Starts and ends just after a rising edge with the bridge idle.
  task automatic run_vec(input vec_t v, input string tag);
    int stalls = 0, reqs = 0, rsp_wait = 0, exp_reqs;
    bit granted = 0, done = 0, bus_ok = 1;
    logic [3:0] be_s = 0;
    logic [31:0] addr_s = 0, wd_s = 0, ld_s = 0;
    logic we_s = 0, lv_s = 0, flt_s = 0;
    logic [1:0] cause_s = 0;
    req_valid_i = 1'b1; req_we_i = v.we; req_addr_i = v.addr;
    req_wdata_i = v.wdata; req_funct3_i = v.f3;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i);
      bus_gnt_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = $urandom;
      if (!stall_o) begin
        done = 1; lv_s = load_valid_o; flt_s = fault_o; cause_s = fault_cause_o; ld_s = load_data_o;
        break;
      end
      stalls++;
      if (bus_req_o) begin
        if (reqs == 0) begin
          be_s = bus_be_o; addr_s = bus_addr_o; wd_s = bus_wdata_o; we_s = bus_we_o;
        end else if (bus_be_o !== be_s || bus_addr_o !== addr_s || bus_wdata_o !== wd_s || bus_we_o !== we_s)
          bus_ok = 0;
        if (reqs == v.gnt_dly) bus_gnt_i = 1'b1;
        reqs++;
      end else begin
        if (bus_be_o !== 4'd0 || bus_addr_o !== 32'd0 || bus_wdata_o !== 32'd0 || bus_we_o !== 1'b0)
          bus_ok = 0;
        if (granted) begin
          if (!v.no_rsp && rsp_wait == v.rsp_dly) begin
            bus_rsp_valid_i = 1'b1; bus_rdata_i = v.rdata; bus_err_i = v.err;
          end
          rsp_wait++;
        end
      end
      if (!granted && !bus_gnt_i && v.noise) begin
        bus_rsp_valid_i = 1'($urandom % 2); bus_err_i = 1'($urandom % 2);
      end
      if (bus_gnt_i) granted = 1;
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0; bus_gnt_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_err_i = 1'b0;
    @(posedge clk_i); #1;
    exp_reqs = (v.be == 4'd0) ? 0 : (v.gnt_dly >= 255) ? 255 : v.gnt_dly + 1;
    chk({tag, " done_seen"}, 32'(done), 32'd1);
    chk({tag, " stall_cycles"}, 32'(stalls), 32'(v.stall));
    chk({tag, " req_cycles"}, 32'(reqs), 32'(exp_reqs));
    if (exp_reqs > 0) begin
      chk({tag, " bus_be"}, 32'(be_s), 32'(v.be));
      chk({tag, " bus_addr"}, addr_s, {v.addr[31:2], 2'b00});
      chk({tag, " bus_wdata"}, wd_s, v.bwdata);
      chk({tag, " bus_we"}, 32'(we_s), 32'(v.we));
    end
    chk({tag, " bus_stable_idle_zero"}, 32'(bus_ok), 32'd1);
    chk({tag, " load_valid"}, 32'(lv_s), 32'(v.lv));
    chk({tag, " fault"}, 32'(flt_s), 32'(v.flt));
    chk({tag, " fault_cause"}, 32'(cause_s), 32'(v.cause));
    if (v.lv) chk({tag, " load_data"}, ld_s, v.ldata);
  endtask

  // Responses arriving while idle must not produce any result.
  task automatic late_rsp(input string tag);
    for (int i = 0; i < 2; i++) begin
      bus_rsp_valid_i = 1'b1; bus_err_i = 1'(i); bus_rdata_i = 32'h5555AAAA;
      @(negedge clk_i);
      chk({tag, " late_rsp_pulse"}, {30'd0, load_valid_o, fault_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    bus_rsp_valid_i = 1'b0; bus_err_i = 1'b0;
    @(negedge clk_i);
    chk({tag, " late_rsp_after"}, {30'd0, load_valid_o, fault_o}, 32'd0);
    @(posedge clk_i); #1;
  endtask

  vec_t dir[14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst_i = 1'b1; req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0; req_funct3_i = 0;
    bus_gnt_i = 0; bus_rsp_valid_i = 0; bus_rdata_i = 0; bus_err_i = 0;

    //            we addr          wdata         f3      g     r  err nr rdata         be    bwdata        lv flt c  ldata         stall
    dir[0]  = mk(0, 32'h100, 32'h0,        3'b010, 0,    0, 0, 0, 32'hDEADBEEF, 4'hF, 32'h0,        1, 0, 0, 32'hDEADBEEF, 3);
    dir[1]  = mk(0, 32'h103, 32'h0,        3'b000, 0,    0, 0, 0, 32'h80FF0000, 4'h8, 32'h0,        1, 0, 0, 32'hFFFFFF80, 3);
    dir[2]  = mk(0, 32'h103, 32'h0,        3'b100, 0,    0, 0, 0, 32'h80FF0000, 4'h8, 32'h0,        1, 0, 0, 32'h00000080, 3);
    dir[3]  = mk(1, 32'h202, 32'h1234ABCD, 3'b001, 2,    0, 0, 0, 32'h0,        4'hC, 32'hABCDABCD, 0, 0, 0, 32'h0,        5);
    dir[4]  = mk(0, 32'h101, 32'h0,        3'b010, 0,    0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 1, 32'h0,        1);
    dir[5]  = mk(0, 32'h010, 32'h0,        3'b001, 0,    0, 1, 0, 32'h00001234, 4'h3, 32'h0,        0, 1, 2, 32'h0,        3);
    dir[6]  = mk(0, 32'h010, 32'h0,        3'b001, 1000, 0, 0, 0, 32'h0,        4'h3, 32'h0,        0, 1, 3, 32'h0,        256);
    dir[7]  = mk(1, 32'h044, 32'hCAFEF00D, 3'b010, 1,    0, 0, 1, 32'h0,        4'hF, 32'hCAFEF00D, 0, 1, 3, 32'h0,        256);
    dir[8]  = mk(0, 32'h012, 32'h0,        3'b101, 1,    2, 0, 0, 32'h80010000, 4'hC, 32'h0,        1, 0, 0, 32'h00008001, 6);
    dir[9]  = mk(0, 32'h012, 32'h0,        3'b001, 0,    0, 0, 0, 32'h80010000, 4'hC, 32'h0,        1, 0, 0, 32'hFFFF8001, 3);
    dir[10] = mk(1, 32'h005, 32'h00000077, 3'b000, 0,    0, 0, 0, 32'h0,        4'h2, 32'h77777777, 0, 0, 0, 32'h0,        3);
    dir[11] = mk(1, 32'h008, 32'h11223344, 3'b100, 0,    0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 1, 32'h0,        1);
    dir[12] = mk(0, 32'h000, 32'h0,        3'b011, 0,    0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 1, 32'h0,        1);
    dir[13] = mk(1, 32'h008, 32'h89ABCDEF, 3'b010, 0,    1, 1, 0, 32'h0,        4'hF, 32'h89ABCDEF, 0, 1, 2, 32'h0,        4);

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset stall", 32'(stall_o), 32'd0);
    chk("reset bus_req", 32'(bus_req_o), 32'd0);
    chk("reset pulses", {30'd0, load_valid_o, fault_o}, 32'd0);
    chk("reset bus_fields", bus_addr_o | bus_wdata_o | 32'(bus_be_o) | 32'(bus_we_o), 32'd0);
    chk("reset load_data_cause", load_data_o | 32'(fault_cause_o), 32'd0);
    @(posedge clk_i); #1;

    for (int i = 0; i < 14; i++) begin
      run_vec(dir[i], $sformatf("dir%0d", i));
      if (i == 6 || i == 7) late_rsp($sformatf("dir%0d", i));
    end

    // Reset while waiting for a response.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h300; req_funct3_i = 3'b010;
    @(negedge clk_i); @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rst_in_rsp req_phase", 32'(bus_req_o), 32'd1);
    bus_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("rst_in_rsp rsp_phase", {30'd0, bus_req_o, stall_o}, 32'd1);
    rst_i = 1'b1; req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_in_rsp outputs", {27'd0, stall_o, bus_req_o, load_valid_o, fault_o, bus_we_o}, 32'd0);
    chk("rst_in_rsp bus_fields", bus_addr_o | 32'(bus_be_o) | 32'(fault_cause_o), 32'd0);
    @(posedge clk_i); #1;
    late_rsp("rst_in_rsp");
    run_vec(mk(0, 32'h300, 32'h0, 3'b010, 0, 0, 0, 0, 32'hA5A55A5A, 4'hF, 32'h0, 1, 0, 0, 32'hA5A55A5A, 3),
            "after_rst");

    for (int i = 0; i < 48; i++) begin
      v.we = 1'($urandom % 2);
      v.f3 = 3'($urandom % 8);
      if (v.we && ($urandom % 4 != 0)) v.f3 = 3'($urandom % 3);
      v.addr = $urandom;
      if ($urandom % 4 != 0) begin
        if (v.f3[1:0] == 2'b01) v.addr[0] = 1'b0;
        if (v.f3[1:0] == 2'b10) v.addr[1:0] = 2'b00;
      end
      v.wdata = $urandom; v.rdata = $urandom;
      v.gnt_dly = int'($urandom % 4); v.rsp_dly = int'($urandom % 4);
      v.err = ($urandom % 6 == 0); v.no_rsp = 1'b0; v.noise = 1'($urandom % 2);
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
